// File: rtl/d__x_multi_test_x_pkg.sv
// Constants and helpers shared by the multi-lane D->X execute stand-in.
package D__XTestPkg;

    localparam int c_err_count_bits = 16;

    // A single-lane build still needs a one-bit lane index.
    function automatic int lane_idx_bits(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/isa_pkg.sv
// Micro-op encoding shared by the decode stage and the execute-side stand-ins.
package ISA;

    typedef enum logic [3:0] {
        UOP_ADD = 4'd0,
        UOP_SUB = 4'd1,
        UOP_AND = 4'd2,
        UOP_OR  = 4'd3,
        UOP_XOR = 4'd4,
        UOP_SLL = 4'd5,
        UOP_SRL = 4'd6,
        UOP_SRA = 4'd7,
        UOP_SLT = 4'd8,
        UOP_BEQ = 4'd9,
        UOP_BNE = 4'd10,
        UOP_JAL = 4'd11
    } rv_uop;

endpackage

// File: rtl/d__x_test_lane.sv
// One D->X channel: expectation FIFO, inter-accept throttle, field comparator
// and the registered squash / branch-target response.
module d__x_test_lane
    import ISA::*;
#(
    parameter int p_addr_bits  = 32,
    parameter int p_data_bits  = 32,
    parameter int p_exp_depth  = 8,
    parameter int p_intv_delay = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [p_addr_bits-1:0] push_pc,
    input  logic [p_data_bits-1:0] push_op1,
    input  logic [p_data_bits-1:0] push_op2,
    input  rv_uop                  push_uop,
    input  logic                   push_squash,
    input  logic [p_addr_bits-1:0] push_target,
    output logic                   full,
    output logic                   empty,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_addr_bits-1:0] pc,
    input  logic [p_data_bits-1:0] op1,
    input  logic [p_data_bits-1:0] op2,
    input  rv_uop                  uop,
    output logic                   squash,
    output logic [p_addr_bits-1:0] branch_target,
    output logic                   mismatch
);

    localparam int c_ptr_bits = $clog2(p_exp_depth);
    localparam int c_dly_bits = (p_intv_delay > 0) ? $clog2(p_intv_delay + 1) : 1;
    localparam logic [c_ptr_bits:0]   c_ptr_one = 1;
    localparam logic [c_dly_bits-1:0] c_dly_one = 1;
    localparam logic [c_dly_bits-1:0] c_dly_init = c_dly_bits'(p_intv_delay);

    typedef struct packed {
        logic [p_addr_bits-1:0] pc;
        logic [p_data_bits-1:0] op1;
        logic [p_data_bits-1:0] op2;
        rv_uop                  uop;
        logic                   squash;
        logic [p_addr_bits-1:0] target;
    } entry_t;

    entry_t                mem [p_exp_depth];
    entry_t                head;
    logic [c_ptr_bits:0]   wr_ptr;
    logic [c_ptr_bits:0]   rd_ptr;
    logic [c_dly_bits-1:0] delay_cnt;
    logic                  accept;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[c_ptr_bits] != rd_ptr[c_ptr_bits]) &&
                    (wr_ptr[c_ptr_bits-1:0] == rd_ptr[c_ptr_bits-1:0]);
    assign head   = mem[rd_ptr[c_ptr_bits-1:0]];
    assign rdy    = !empty && (delay_cnt == '0);
    assign accept = val && rdy;

    assign mismatch = accept && ((pc  != head.pc)  || (op1 != head.op1) ||
                                 (op2 != head.op2) || (uop != head.uop));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[c_ptr_bits-1:0]] <= '{pc: push_pc, op1: push_op1, op2: push_op2,
                                             uop: push_uop, squash: push_squash,
                                             target: push_target};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            delay_cnt     <= '0;
            squash        <= 1'b0;
            branch_target <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + c_ptr_one;
            end
            if (accept) begin
                rd_ptr    <= rd_ptr + c_ptr_one;
                delay_cnt <= c_dly_init;
            end else if (delay_cnt != '0) begin
                delay_cnt <= delay_cnt - c_dly_one;
            end
            // Squash is a one-cycle pulse; the target is zero whenever it is low.
            squash        <= accept && head.squash;
            branch_target <= (accept && head.squash) ? head.target : '0;
        end
    end

endmodule

// File: rtl/d__x_multi_test_x.sv
// Multi-lane execute-side stand-in: routes expectation loads to per-lane
// checkers and accumulates their mismatches into sticky status.
module d__x_multi_test_x
    import ISA::*;
    import D__XTestPkg::*;
#(
    parameter int p_num_lanes  = 2,
    parameter int p_addr_bits  = 32,
    parameter int p_data_bits  = 32,
    parameter int p_exp_depth  = 8,
    parameter int p_intv_delay = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [p_num_lanes-1:0]                  dut_val,
    output logic [p_num_lanes-1:0]                  dut_rdy,
    input  logic [p_num_lanes-1:0][p_addr_bits-1:0] dut_pc,
    input  logic [p_num_lanes-1:0][p_data_bits-1:0] dut_op1,
    input  logic [p_num_lanes-1:0][p_data_bits-1:0] dut_op2,
    input  rv_uop [p_num_lanes-1:0]                 dut_uop,
    output logic [p_num_lanes-1:0]                  dut_squash,
    output logic [p_num_lanes-1:0][p_addr_bits-1:0] dut_branch_target,
    input  logic                                    exp_val,
    output logic                                    exp_rdy,
    input  logic [lane_idx_bits(p_num_lanes)-1:0]   exp_lane,
    input  logic [p_addr_bits-1:0]                  exp_pc,
    input  logic [p_data_bits-1:0]                  exp_op1,
    input  logic [p_data_bits-1:0]                  exp_op2,
    input  rv_uop                                   exp_uop,
    input  logic                                    exp_squash,
    input  logic [p_addr_bits-1:0]                  exp_target,
    output logic                                    done,
    output logic                                    err,
    output logic [lane_idx_bits(p_num_lanes)-1:0]   err_lane,
    output logic [c_err_count_bits-1:0]             err_count
);

    localparam int c_lane_bits = lane_idx_bits(p_num_lanes);
    localparam logic [c_err_count_bits:0] c_hit_one = 1;

    typedef struct packed {
        logic [p_addr_bits-1:0] pc;
        logic [p_data_bits-1:0] op1;
        logic [p_data_bits-1:0] op2;
        rv_uop                  uop;
        logic                   squash;
        logic [p_addr_bits-1:0] target;
    } exp_entry_t;

    exp_entry_t                  load_entry;
    logic [p_num_lanes-1:0]      push;
    logic [p_num_lanes-1:0]      full;
    logic [p_num_lanes-1:0]      empty;
    logic [p_num_lanes-1:0]      mismatch;
    logic [c_err_count_bits:0]   err_hits;
    logic [c_err_count_bits:0]   count_sum;
    logic [c_err_count_bits-1:0] count_next;
    logic [c_lane_bits-1:0]      first_lane;

    assign load_entry = '{pc: exp_pc, op1: exp_op1, op2: exp_op2, uop: exp_uop,
                          squash: exp_squash, target: exp_target};

    // Out-of-range lanes never match, so they leave exp_rdy low.
    always_comb begin
        exp_rdy = 1'b0;
        for (int i = 0; i < p_num_lanes; i++) begin
            if (exp_lane == c_lane_bits'(i)) begin
                exp_rdy = !full[i];
            end
        end
        if (rst) begin
            exp_rdy = 1'b0;
        end
    end

    always_comb begin
        push = '0;
        for (int i = 0; i < p_num_lanes; i++) begin
            push[i] = exp_val && exp_rdy && (exp_lane == c_lane_bits'(i));
        end
    end

    for (genvar g = 0; g < p_num_lanes; g++) begin : g_lane
        d__x_test_lane #(
            .p_addr_bits  (p_addr_bits),
            .p_data_bits  (p_data_bits),
            .p_exp_depth  (p_exp_depth),
            .p_intv_delay (p_intv_delay)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .push          (push[g]),
            .push_pc       (load_entry.pc),
            .push_op1      (load_entry.op1),
            .push_op2      (load_entry.op2),
            .push_uop      (load_entry.uop),
            .push_squash   (load_entry.squash),
            .push_target   (load_entry.target),
            .full          (full[g]),
            .empty         (empty[g]),
            .val           (dut_val[g]),
            .rdy           (dut_rdy[g]),
            .pc            (dut_pc[g]),
            .op1           (dut_op1[g]),
            .op2           (dut_op2[g]),
            .uop           (dut_uop[g]),
            .squash        (dut_squash[g]),
            .branch_target (dut_branch_target[g]),
            .mismatch      (mismatch[g])
        );
    end

    // Scanning downwards leaves first_lane at the lowest mismatching lane.
    always_comb begin
        err_hits   = '0;
        first_lane = '0;
        for (int i = p_num_lanes - 1; i >= 0; i--) begin
            if (mismatch[i]) begin
                err_hits   = err_hits + c_hit_one;
                first_lane = c_lane_bits'(i);
            end
        end
        count_sum  = {1'b0, err_count} + err_hits;
        count_next = count_sum[c_err_count_bits] ? '1 : count_sum[c_err_count_bits-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_lane  <= '0;
            err_count <= '0;
        end else if (|mismatch) begin
            err       <= 1'b1;
            err_count <= count_next;
            if (!err) begin
                err_lane <= first_lane;
            end
        end
    end

    assign done = (&empty) && !(|dut_squash);

endmodule

// File: tb/tb_d__x_multi_test_x.sv
// Directed bench for the multi-lane D->X stand-in: one instance with no
// inter-accept delay and one with a delay of 2, driven from shared inputs.
module tb_d__x_multi_test_x;
    import ISA::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        dut_val;
    logic [1:0][31:0]  dut_pc;
    logic [1:0][31:0]  dut_op1;
    logic [1:0][31:0]  dut_op2;
    rv_uop [1:0]       dut_uop;
    logic              exp_val;
    logic [0:0]        exp_lane;
    logic [31:0]       exp_pc;
    logic [31:0]       exp_op1;
    logic [31:0]       exp_op2;
    rv_uop             exp_uop;
    logic              exp_squash;
    logic [31:0]       exp_target;

    logic [1:0]        dut_rdy, rdy_d;
    logic [1:0]        dut_squash, squash_d;
    logic [1:0][31:0]  dut_branch_target, target_d;
    logic              exp_rdy, exp_rdy_d;
    logic              done, done_d;
    logic              err, err_d;
    logic [0:0]        err_lane, err_lane_d;
    logic [15:0]       err_count, err_count_d;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    d__x_multi_test_x #(.p_num_lanes(2), .p_addr_bits(32), .p_data_bits(32),
                        .p_exp_depth(8), .p_intv_delay(0)) dut (
        .clk(clk), .rst(rst),
        .dut_val(dut_val), .dut_rdy(dut_rdy), .dut_pc(dut_pc),
        .dut_op1(dut_op1), .dut_op2(dut_op2), .dut_uop(dut_uop),
        .dut_squash(dut_squash), .dut_branch_target(dut_branch_target),
        .exp_val(exp_val), .exp_rdy(exp_rdy), .exp_lane(exp_lane),
        .exp_pc(exp_pc), .exp_op1(exp_op1), .exp_op2(exp_op2), .exp_uop(exp_uop),
        .exp_squash(exp_squash), .exp_target(exp_target),
        .done(done), .err(err), .err_lane(err_lane), .err_count(err_count)
    );

    d__x_multi_test_x #(.p_num_lanes(2), .p_addr_bits(32), .p_data_bits(32),
                        .p_exp_depth(8), .p_intv_delay(2)) dut_dly (
        .clk(clk), .rst(rst),
        .dut_val(dut_val), .dut_rdy(rdy_d), .dut_pc(dut_pc),
        .dut_op1(dut_op1), .dut_op2(dut_op2), .dut_uop(dut_uop),
        .dut_squash(squash_d), .dut_branch_target(target_d),
        .exp_val(exp_val), .exp_rdy(exp_rdy_d), .exp_lane(exp_lane),
        .exp_pc(exp_pc), .exp_op1(exp_op1), .exp_op2(exp_op2), .exp_uop(exp_uop),
        .exp_squash(exp_squash), .exp_target(exp_target),
        .done(done_d), .err(err_d), .err_lane(err_lane_d), .err_count(err_count_d)
    );

    typedef struct {
        logic        lane;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        rv_uop       uop;
        logic        sq;
        logic [31:0] tgt;
        logic [1:0]  squash_exp;
        logic [31:0] target_exp;
        logic        done_exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic lane, input logic [31:0] pc, input logic [31:0] op1,
                        input logic [31:0] op2, input rv_uop uop, input logic sq,
                        input logic [31:0] tgt);
        exp_val    = 1'b1;
        exp_lane   = lane;
        exp_pc     = pc;
        exp_op1    = op1;
        exp_op2    = op2;
        exp_uop    = uop;
        exp_squash = sq;
        exp_target = tgt;
        tick();
        exp_val = 1'b0;
    endtask

    task automatic send(input logic lane, input logic [31:0] pc, input logic [31:0] op1,
                        input logic [31:0] op2, input rv_uop uop);
        dut_val[lane] = 1'b1;
        dut_pc[lane]  = pc;
        dut_op1[lane] = op1;
        dut_op2[lane] = op2;
        dut_uop[lane] = uop;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        dut_val = '0;
        exp_val = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_val    = 1'b1;
        exp_lane   = v.lane;
        exp_pc     = v.pc;
        exp_op1    = v.op1;
        exp_op2    = v.op2;
        exp_uop    = v.uop;
        exp_squash = v.sq;
        exp_target = v.tgt;
        #1;
        check("vec_exp_rdy", exp_rdy, 1);
        check("vec_rdy_before_load", dut_rdy[v.lane], 0);
        tick();
        exp_val = 1'b0;
        check("vec_rdy_after_load", dut_rdy[v.lane], 1);
        send(v.lane, v.pc, v.op1, v.op2, v.uop);
        #1;
        check("vec_squash_in_accept_cycle", dut_squash, 0);
        tick();
        dut_val = '0;
        #1;
    endtask

    task automatic check_output(input vec_t v);
        logic other;
        other = ~v.lane;
        check("vec_squash", dut_squash, v.squash_exp);
        check("vec_target", dut_branch_target[v.lane], v.target_exp);
        check("vec_target_other", dut_branch_target[other], 0);
        check("vec_done", done, v.done_exp);
        check("vec_err", err, 0);
        tick();
        check("vec_squash_gone", dut_squash, 0);
        check("vec_target_gone", dut_branch_target, 0);
        check("vec_done_after", done, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        int          loaded;
        int          popped;
        int          cyc;
        int          acc_d [$];
        int          acc_0 [$];
        logic        do_push;
        logic        do_pop;

        vecs[0] = '{1'b0, 32'h200, 32'd5, 32'd7, UOP_ADD, 1'b0, 32'h0, 2'b00, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 32'h300, 32'd1, 32'd2, UOP_SUB, 1'b1, 32'h400, 2'b10, 32'h400, 1'b0};
        vecs[2] = '{1'b0, 32'h204, 32'hFFFF_FFFF, 32'd3, UOP_AND, 1'b1, 32'h1234, 2'b01, 32'h1234, 1'b0};
        vecs[3] = '{1'b1, 32'h308, 32'd0, 32'd0, UOP_XOR, 1'b0, 32'hDEAD, 2'b00, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 32'h20C, 32'd9, 32'd9, UOP_SLT, 1'b1, 32'h0, 2'b01, 32'h0, 1'b0};

        rst        = 1'b1;
        dut_val    = '0;
        dut_pc     = '0;
        dut_op1    = '0;
        dut_op2    = '0;
        dut_uop    = {UOP_ADD, UOP_ADD};
        exp_val    = 1'b0;
        exp_lane   = 1'b0;
        exp_pc     = '0;
        exp_op1    = '0;
        exp_op2    = '0;
        exp_uop    = UOP_ADD;
        exp_squash = 1'b0;
        exp_target = '0;
        #1;
        check("reset_rdy", dut_rdy, 0);
        check("reset_squash", dut_squash, 0);
        check("reset_target", dut_branch_target, 0);
        check("reset_exp_rdy", exp_rdy, 0);
        check("reset_done", done, 1);
        check("reset_err", err, 0);
        check("reset_err_lane", err_lane, 0);
        check("reset_err_count", err_count, 0);
        tick();
        rst = 1'b0;
        #1;

        $display("[TB] single-transaction vectors");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i]);
        end

        $display("[TB] inter-accept spacing");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 32'h500, 32'd1, 32'd2, UOP_OR, 1'b0, 32'h0);
        end
        send(1'b0, 32'h500, 32'd1, 32'd2, UOP_OR);
        #1;
        for (int c = 0; c < 16; c++) begin
            if (rdy_d[0]) acc_d.push_back(c);
            if (dut_rdy[0]) acc_0.push_back(c);
            tick();
        end
        dut_val = '0;
        #1;
        check("spacing_count", acc_d.size(), 3);
        if (acc_d.size() == 3) begin
            check("spacing_first", acc_d[0], 0);
            check("spacing_gap1", acc_d[1] - acc_d[0], 3);
            check("spacing_gap2", acc_d[2] - acc_d[1], 3);
        end
        check("b2b_count", acc_0.size(), 3);
        if (acc_0.size() == 3) begin
            check("b2b_last", acc_0[2], 2);
        end
        check("spacing_err", err_d, 0);
        check("spacing_err_count", err_count_d, 0);
        check("spacing_err_lane", err_lane_d, 0);
        check("spacing_done", done_d, 1);
        check("spacing_squash", squash_d, 0);
        check("spacing_target", target_d, 0);
        check("spacing_exp_rdy", exp_rdy_d, 1);
        check("b2b_err", err, 0);

        $display("[TB] full queue and wrap");
        do_reset();
        loaded = 0;
        popped = 0;
        for (int i = 0; i < 8; i++) begin
            exp_val = 1'b1; exp_lane = 1'b0; exp_pc = 32'h1000 + loaded;
            exp_op1 = 32'h11; exp_op2 = 32'h22; exp_uop = UOP_ADD; exp_squash = 1'b0;
            #1;
            check("fill_exp_rdy", exp_rdy, 1);
            tick();
            q.push_back(32'h1000 + loaded);
            loaded++;
        end
        exp_pc = 32'h1000 + loaded;
        #1;
        check("full_exp_rdy", exp_rdy, 0);
        exp_lane = 1'b1;
        #1;
        check("other_lane_exp_rdy", exp_rdy, 1);
        exp_lane = 1'b0;
        send(1'b0, q[0], 32'h11, 32'h22, UOP_ADD);
        #1;
        check("pop_load_refused", exp_rdy, 0);
        tick();
        void'(q.pop_front());
        popped++;
        dut_val = '0;
        exp_val = 1'b0;
        #1;
        check("after_pop_exp_rdy", exp_rdy, 1);
        cyc = 0;
        while (popped < 20 && cyc < 200) begin
            exp_val = (loaded < 20);
            exp_pc  = 32'h1000 + loaded;
            dut_val[0] = (q.size() > 0) && (cyc % 3 != 0);
            dut_pc[0]  = (q.size() > 0) ? q[0] : 32'h0;
            #1;
            check("wrap_exp_rdy", exp_rdy, q.size() < 8);
            check("wrap_rdy", dut_rdy[0], q.size() > 0);
            do_push = exp_val && (q.size() < 8);
            do_pop  = dut_val[0] && (q.size() > 0);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(32'h1000 + loaded);
                loaded++;
            end
            cyc++;
        end
        dut_val = '0;
        exp_val = 1'b0;
        #1;
        check("wrap_popped", popped, 20);
        check("wrap_loaded", loaded, 20);
        check("wrap_err", err, 0);
        check("wrap_done", done, 1);

        $display("[TB] error accumulation");
        do_reset();
        load(1'b0, 32'h600, 32'd1, 32'd2, UOP_ADD, 1'b0, 32'h0);
        load(1'b1, 32'h700, 32'd3, 32'd4, UOP_SUB, 1'b0, 32'h0);
        send(1'b0, 32'h600, 32'd1, 32'h99, UOP_ADD);
        send(1'b1, 32'h700, 32'd3, 32'h98, UOP_SUB);
        #1;
        check("err_before_accept", err, 0);
        tick();
        dut_val = '0;
        check("dual_err_count", err_count, 2);
        check("dual_err", err, 1);
        check("dual_err_lane", err_lane, 0);
        tick();
        check("err_sticky", err, 1);
        check("err_count_hold", err_count, 2);
        load(1'b1, 32'h704, 32'd5, 32'd6, UOP_OR, 1'b0, 32'h0);
        send(1'b1, 32'h704, 32'h55, 32'd6, UOP_OR);
        tick();
        dut_val = '0;
        check("later_err_count", err_count, 3);
        check("later_err_lane", err_lane, 0);
        check("later_err", err, 1);

        $display("[TB] reset mid-stream");
        load(1'b0, 32'h800, 32'd1, 32'd1, UOP_JAL, 1'b1, 32'h900);
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 32'h804 + 4 * i, 32'd1, 32'd1, UOP_ADD, 1'b0, 32'h0);
        end
        send(1'b0, 32'h800, 32'd1, 32'd1, UOP_JAL);
        tick();
        dut_val = '0;
        check("pre_reset_squash", dut_squash, 2'b01);
        check("pre_reset_target", dut_branch_target[0], 32'h900);
        rst = 1'b1;
        #1;
        check("mid_reset_squash", dut_squash, 0);
        check("mid_reset_target", dut_branch_target, 0);
        check("mid_reset_done", done, 1);
        check("mid_reset_rdy", dut_rdy, 0);
        check("mid_reset_exp_rdy", exp_rdy, 0);
        check("mid_reset_err", err, 0);
        check("mid_reset_err_lane", err_lane, 0);
        check("mid_reset_err_count", err_count, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_reset_exp_rdy", exp_rdy, 1);
        tick();
        check("post_reset_rdy", dut_rdy, 0);
        check("post_reset_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
